// File: rtl/riscv_pkg.sv
// Shared RV64I constants and types for the execute front end.
package riscv_pkg;

  localparam int unsigned XLEN = 64;

  typedef enum logic [3:0] {
    ALU_AND = 4'b0000,
    ALU_OR  = 4'b0001,
    ALU_ADD = 4'b0010,
    ALU_SUB = 4'b0110,
    ALU_NOR = 4'b1100
  } alu_op_e;

  typedef enum logic [1:0] {
    AOP_MEM    = 2'b00,
    AOP_BRANCH = 2'b01,
    AOP_RTYPE  = 2'b10,
    AOP_ITYPE  = 2'b11
  } alu_op2_e;

  localparam logic [2:0] F3_ADD = 3'b000;
  localparam logic [2:0] F3_OR  = 3'b110;
  localparam logic [2:0] F3_AND = 3'b111;

  // Contents of the ID/EX register; all-zero is the bubble.
  typedef struct packed {
    logic [XLEN-1:0] rs1_data;
    logic [XLEN-1:0] rs2_data;
    logic [XLEN-1:0] imm;
    logic [4:0]      rs1;
    logic [4:0]      rs2;
    logic [4:0]      rd;
    logic [2:0]      funct3;
    logic            funct7_5;
    alu_op2_e        alu_op2;
    logic            alu_src;
    logic            mem_read;
    logic            mem_write;
    logic            reg_write;
    logic            mem_to_reg;
    logic            branch;
  } id_ex_t;

endpackage

// File: rtl/id_ex_stage_alu_control.sv
// ALU-control decode: (alu_op2, funct3, funct7_5) -> 4-bit ALU operation.
module alu_control
  import riscv_pkg::*;
(
  input  logic [1:0] alu_op2,
  input  logic [2:0] funct3,
  input  logic       funct7_5,
  output logic [3:0] alu_op
);

  always_comb begin
    alu_op = ALU_ADD;
    case (alu_op2_e'(alu_op2))
      AOP_MEM:    alu_op = ALU_ADD;
      AOP_BRANCH: alu_op = ALU_SUB;
      AOP_RTYPE: begin
        case (funct3)
          F3_ADD:  alu_op = funct7_5 ? ALU_SUB : ALU_ADD;
          F3_AND:  alu_op = ALU_AND;
          F3_OR:   alu_op = ALU_OR;
          default: alu_op = ALU_ADD;
        endcase
      end
      AOP_ITYPE: begin
        case (funct3)
          F3_AND:  alu_op = ALU_AND;
          F3_OR:   alu_op = ALU_OR;
          default: alu_op = ALU_ADD;
        endcase
      end
      default: alu_op = ALU_ADD;
    endcase
  end

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with operand forwarding, ALU-control decode and
// load-use bubble insertion.
module id_ex_stage
  import riscv_pkg::*;
(
  input  logic            clk,
  input  logic            reset,
  input  logic            stall,
  input  logic            flush,
  input  logic [XLEN-1:0] id_rs1_data,
  input  logic [XLEN-1:0] id_rs2_data,
  input  logic [XLEN-1:0] id_imm,
  input  logic [4:0]      id_rs1,
  input  logic [4:0]      id_rs2,
  input  logic [4:0]      id_rd,
  input  logic [2:0]      id_funct3,
  input  logic            id_funct7_5,
  input  logic [1:0]      id_alu_op2,
  input  logic            id_alu_src,
  input  logic            id_mem_read,
  input  logic            id_mem_write,
  input  logic            id_reg_write,
  input  logic            id_mem_to_reg,
  input  logic            id_branch,
  input  logic            exmem_reg_write,
  input  logic [4:0]      exmem_rd,
  input  logic [XLEN-1:0] exmem_result,
  input  logic            memwb_reg_write,
  input  logic [4:0]      memwb_rd,
  input  logic [XLEN-1:0] memwb_result,
  output logic [XLEN-1:0] alu_a,
  output logic [XLEN-1:0] alu_b,
  output logic [3:0]      alu_op,
  output logic [XLEN-1:0] ex_store_data,
  output logic [XLEN-1:0] ex_imm,
  output logic [4:0]      ex_rd,
  output logic            ex_mem_read,
  output logic            ex_mem_write,
  output logic            ex_reg_write,
  output logic            ex_mem_to_reg,
  output logic            ex_branch,
  output logic            load_use_stall
);

  id_ex_t ex;

  assign load_use_stall = ex.mem_read && (ex.rd != 5'd0) &&
                          ((ex.rd == id_rs1) || (ex.rd == id_rs2));

  always_ff @(posedge clk) begin
    if (reset || flush) begin
      ex <= '0;
    end else if (!stall) begin
      if (load_use_stall) begin
        ex <= '0;
      end else begin
        ex <= '{rs1_data:   id_rs1_data,
                rs2_data:   id_rs2_data,
                imm:        id_imm,
                rs1:        id_rs1,
                rs2:        id_rs2,
                rd:         id_rd,
                funct3:     id_funct3,
                funct7_5:   id_funct7_5,
                alu_op2:    alu_op2_e'(id_alu_op2),
                alu_src:    id_alu_src,
                mem_read:   id_mem_read,
                mem_write:  id_mem_write,
                reg_write:  id_reg_write,
                mem_to_reg: id_mem_to_reg,
                branch:     id_branch};
      end
    end
  end

  logic [XLEN-1:0] fwd_rs1, fwd_rs2;

  // EX/MEM is the younger result, so it is tested first; x0 never forwards.
  always_comb begin
    fwd_rs1 = ex.rs1_data;
    if (exmem_reg_write && (exmem_rd != 5'd0) && (exmem_rd == ex.rs1))
      fwd_rs1 = exmem_result;
    else if (memwb_reg_write && (memwb_rd != 5'd0) && (memwb_rd == ex.rs1))
      fwd_rs1 = memwb_result;

    fwd_rs2 = ex.rs2_data;
    if (exmem_reg_write && (exmem_rd != 5'd0) && (exmem_rd == ex.rs2))
      fwd_rs2 = exmem_result;
    else if (memwb_reg_write && (memwb_rd != 5'd0) && (memwb_rd == ex.rs2))
      fwd_rs2 = memwb_result;
  end

  assign alu_a         = fwd_rs1;
  assign ex_store_data = fwd_rs2;
  assign alu_b         = ex.alu_src ? ex.imm : fwd_rs2;

  assign ex_imm        = ex.imm;
  assign ex_rd         = ex.rd;
  assign ex_mem_read   = ex.mem_read;
  assign ex_mem_write  = ex.mem_write;
  assign ex_reg_write  = ex.reg_write;
  assign ex_mem_to_reg = ex.mem_to_reg;
  assign ex_branch     = ex.branch;

  alu_control u_alu_control (
    .alu_op2  (ex.alu_op2),
    .funct3   (ex.funct3),
    .funct7_5 (ex.funct7_5),
    .alu_op   (alu_op)
  );

endmodule
